// File: rtl/float_mul_iter.sv
// rtl/float_mul_iter.sv - iterative shift-add floating-point multiplier
// Purpose: multiplies two {sign, exp, mant} floats, retiring BITS_PER_CYCLE
//   multiplier bits per clock, then one normalise/round cycle.
//   Zero/denormal inputs flush to +0; all-ones exponent inputs give inf.
//   Overflow saturates to inf, underflow flushes to +0.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active-high
//   req  - operand request, sampled only while idle
//   a, b - operands, sampled with req
//   busy - high while an operation is in flight (registered)
//   ack  - one-cycle pulse, result valid on out
//   out  - product, zero whenever ack is low
// Configuration: define FLOAT_MUL_ROUND_NEAREST_EN for round-to-nearest-even;
//   otherwise the fraction is truncated. Latency is the same in both builds.
module float_mul_iter #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANT_WIDTH     = 23,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req,
  input  logic [EXP_WIDTH+MANT_WIDTH:0]     a,
  input  logic [EXP_WIDTH+MANT_WIDTH:0]     b,
  output logic                              busy,
  output logic                              ack,
  output logic [EXP_WIDTH+MANT_WIDTH:0]     out
);

  localparam int W    = 1 + EXP_WIDTH + MANT_WIDTH;
  localparam int M    = MANT_WIDTH;
  localparam int N    = (MANT_WIDTH + 1) / BITS_PER_CYCLE;
  localparam int PW   = 2 * MANT_WIDTH + 2;
  localparam int EXW  = EXP_WIDTH + 2;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int BIAS = (1 << (EXP_WIDTH - 1)) - 1;
  localparam logic [EXW-1:0] EXP_MAX = EXW'((1 << EXP_WIDTH) - 1);

  generate
    if (((MANT_WIDTH + 1) % BITS_PER_CYCLE) != 0) begin : g_bad_radix
      $error("BITS_PER_CYCLE must divide MANT_WIDTH+1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, MUL, NORM} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [M:0]      ma_q, ma_d, mb_q, mb_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [EXW-1:0]  exp_q, exp_d;
  logic            sign_q, sign_d;
  logic            busy_q, busy_d;
  logic            ack_q, ack_d;
  logic [W-1:0]    out_q, out_d;

  // Combinational helpers
  logic [EXP_WIDTH-1:0] ea, eb;
  logic [M:0]           mb_shift;
  logic [PW-1:0]        pp;
  int unsigned          sh;
  logic [EXW-1:0]       e_n;
  logic [M:0]           frac_n;   // extra top bit catches the rounding carry

  assign ea = a[W-2:M];
  assign eb = b[W-2:M];

`ifdef FLOAT_MUL_ROUND_NEAREST_EN
  logic guard, sticky;
  // Bit positions depend on whether the product landed in [2,4) or [1,2).
  assign guard  = prod_q[PW-1] ? prod_q[M]       : prod_q[M-1];
  assign sticky = prod_q[PW-1] ? (|prod_q[M-1:0]) : (|prod_q[M-2:0]);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      prod_q  <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      prod_q  <= prod_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    prod_d   = prod_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    ack_d    = 1'b0;
    out_d    = '0;
    sh       = int'(cnt_q) * BITS_PER_CYCLE;
    mb_shift = mb_q >> sh;
    pp       = (PW'(ma_q) * PW'(mb_shift[BITS_PER_CYCLE-1:0])) << sh;
    e_n      = '0;
    frac_n   = '0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (ea == '0 || eb == '0) begin
            ack_d = 1'b1;
          end else if ((&ea) || (&eb)) begin
            ack_d = 1'b1;
            out_d = {a[W-1] ^ b[W-1], {EXP_WIDTH{1'b1}}, {M{1'b0}}};
          end else begin
            ma_d    = {1'b1, a[M-1:0]};
            mb_d    = {1'b1, b[M-1:0]};
            prod_d  = '0;
            exp_d   = EXW'(ea) + EXW'(eb) - EXW'(BIAS);
            sign_d  = a[W-1] ^ b[W-1];
            cnt_d   = '0;
            state_d = MUL;
          end
        end
      end
      MUL: begin
        prod_d = prod_q + pp;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = NORM;
        end
      end
      NORM: begin
        if (prod_q[PW-1]) begin
          e_n    = exp_q + EXW'(1);
          frac_n = {1'b0, prod_q[PW-2:M+1]};
        end else begin
          e_n    = exp_q;
          frac_n = {1'b0, prod_q[PW-3:M]};
        end
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
        frac_n = frac_n + (M+1)'(guard & (sticky | frac_n[0]));
`endif
        // Rounding overflowed the fraction: value is exactly the next power of two.
        if (frac_n[M]) begin
          frac_n = '0;
          e_n    = e_n + EXW'(1);
        end
        ack_d   = 1'b1;
        state_d = IDLE;
        // e_n is two's complement; its top bit marks a negative exponent.
        if (!e_n[EXW-1] && e_n >= EXP_MAX) begin
          out_d = {sign_q, {EXP_WIDTH{1'b1}}, {M{1'b0}}};
        end else if (e_n[EXW-1] || e_n == '0) begin
          out_d = '0;
        end else begin
          out_d = {sign_q, e_n[EXP_WIDTH-1:0], frac_n[M-1:0]};
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign busy = busy_q;
  assign ack  = ack_q;
  assign out  = out_q;

endmodule

// File: tb/tb_float_mul_iter.sv
// tb/tb_float_mul_iter.sv - randomized self-checking bench for float_mul_iter (fp32 defaults)
module tb_float_mul_iter;

  localparam int EW  = 8;
  localparam int MW  = 23;
  localparam int BPC = 2;
  localparam int W   = 32;
  localparam int N   = (MW + 1) / BPC;
  localparam int LAT = N + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req = 1'b0;
  logic [W-1:0] a   = '0;
  logic [W-1:0] b   = '0;
  logic         busy;
  logic         ack;
  logic [W-1:0] prod;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  float_mul_iter #(.EXP_WIDTH(EW), .MANT_WIDTH(MW), .BITS_PER_CYCLE(BPC)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .a    (a),
    .b    (b),
    .busy (busy),
    .ack  (ack),
    .out  (prod)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference product from real-number rules on integer significands.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    int              ex, ey, e, sh;
    logic            s;
    longint unsigned p, sig;
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
    longint unsigned rem, half;
`endif
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    if (ex == 0 || ey == 0) return 32'h0;
    if (ex == 255 || ey == 255) return {s, 8'hFF, 23'h0};
    p  = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
    e  = ex + ey - 127;
    sh = (p >= (64'd1 << 47)) ? 24 : 23;
    if (sh == 24) e++;
    sig = p >> sh;
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
    rem  = p - (sig << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && sig[0])) sig++;
`endif
    if (sig == (64'd1 << 24)) begin
      sig = 64'd1 << 23;
      e++;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return 32'h0;
    return {s, 8'(e), sig[22:0]};
  endfunction

  function automatic int exp_latency(input logic [31:0] x, input logic [31:0] y);
    if (x[30:23] == 8'h00 || y[30:23] == 8'h00 || x[30:23] == 8'hFF || y[30:23] == 8'hFF)
      return 0;
    return LAT;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0)      e = 8'h00;
    else if (r == 1) e = 8'hFF;
    else             e = 8'($urandom_range(1, 254));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // Issue one request and wait (bounded) for its ack; lat counts clock edges after the accept edge.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat, output bit busy_ok);
    @(negedge clk);
    req = 1'b1; a = x; b = y;
    @(negedge clk);
    req = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!ack && lat < 4 * LAT) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    res = prod;
  endtask

  task automatic do_check(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp);
    logic [31:0] res;
    int          lat;
    bit          busy_ok;
    run_op(x, y, res, lat, busy_ok);
    check_eq({tag, "_ack"}, 32'(ack), 32'd1);
    check_eq({tag, "_out"}, res, exp);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_latency(x, y)));
    check_eq({tag, "_busy_run"}, 32'(busy_ok), 32'd1);
    check_eq({tag, "_busy_at_ack"}, 32'(busy), 32'd0);
    @(negedge clk);
    check_eq({tag, "_ack_pulse"}, 32'(ack), 32'd0);
    check_eq({tag, "_out_idle"}, prod, 32'h0);
  endtask

  initial begin
    logic [31:0] bx[3];
    logic [31:0] by[3];
    int          tacks[3];
    int          t, acks, n;
    logic [31:0] x, y, res;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_out", prod, 32'h0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Directed vectors
    do_check("d_1p5x2",   32'h3FC00000, 32'h40000000, 32'h40400000);
    do_check("d_zero",    32'h00000000, 32'h40490FDB, 32'h00000000);
    do_check("d_neg",     32'hC0000000, 32'h40400000, 32'hC0C00000);
    do_check("d_ovf",     32'h7F000000, 32'h7F000000, 32'h7F800000);
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
    do_check("d_round",   32'h3F800001, 32'h3FC00000, 32'h3FC00002);
`else
    do_check("d_round",   32'h3F800001, 32'h3FC00000, 32'h3FC00001);
`endif
    do_check("d_unf",     32'h00800000, 32'h00800000, 32'h00000000);
    do_check("d_inf",     32'hFF800000, 32'h3F800000, 32'hFF800000);
    do_check("d_zeroinf", 32'h7F800000, 32'h00000000, 32'h00000000);
    do_check("d_denorm",  32'h80000001, 32'h3F800000, 32'h00000000);

    // Randomized against the model
    for (int i = 0; i < 40; i++) begin
      x = rand_op();
      y = rand_op();
      do_check("rnd", x, y, ref_mul(x, y));
    end

    // Back-to-back with req held high
    for (int i = 0; i < 3; i++) begin
      bx[i] = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
      by[i] = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
      tacks[i] = 0;
    end
    @(negedge clk);
    req = 1'b1; a = bx[0]; b = by[0];
    t = 0;
    acks = 0;
    while (acks < 3 && t < 10 * LAT) begin
      @(negedge clk);
      t++;
      if (ack) begin
        check_eq("b2b_out", prod, ref_mul(bx[acks], by[acks]));
        tacks[acks] = t;
        acks++;
        if (acks < 3) begin
          a = bx[acks]; b = by[acks];
        end else begin
          req = 1'b0;
        end
      end
    end
    req = 1'b0;
    check_eq("b2b_count", 32'(acks), 32'd3);
    check_eq("b2b_gap1", 32'(tacks[1] - tacks[0]), 32'(LAT + 1));
    check_eq("b2b_gap2", 32'(tacks[2] - tacks[1]), 32'(LAT + 1));
    n = 0;
    repeat (2 * LAT) begin
      @(negedge clk);
      if (ack) n++;
    end
    check_eq("b2b_no_extra", 32'(n), 32'd0);

    // Request pulse while busy is dropped
    x = 32'h40A00000;
    y = 32'hBFC00000;
    @(negedge clk);
    req = 1'b1; a = x; b = y;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    req = 1'b1; a = 32'h3F800000; b = 32'h3F800000;
    @(negedge clk);
    req = 1'b0; a = '0; b = '0;
    t = 0;
    while (!ack && t < 4 * LAT) begin
      @(negedge clk);
      t++;
    end
    check_eq("ign_ack", 32'(ack), 32'd1);
    check_eq("ign_out", prod, 32'hC0F00000);
    n = 0;
    repeat (2 * LAT) begin
      @(negedge clk);
      if (ack) n++;
    end
    check_eq("ign_no_extra", 32'(n), 32'd0);

    // Reset in the middle of MUL (cnt = 5)
    @(negedge clk);
    req = 1'b1; a = 32'h3FC00000; b = 32'h40000000;
    @(negedge clk);
    req = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ack", 32'(ack), 32'd0);
    check_eq("mid_rst_out", prod, 32'h0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (2 * LAT) begin
      @(negedge clk);
      if (ack) n++;
    end
    check_eq("mid_no_ack", 32'(n), 32'd0);
    do_check("post_rst", 32'hC0000000, 32'h40400000, 32'hC0C00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
